// File: rtl/pe_load_sequencer.sv
// rtl/pe_load_sequencer.sv - per-channel segment load sequencer feeding PE fmap/weight FIFOs
// Each channel waits for an optional release, pulses start, then streams len words.
module pe_load_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_NUM     = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_NUM-1:0]            cmd_valid,
    output logic [CH_NUM-1:0]            cmd_ready,
    input  logic [CH_NUM*LEN_WIDTH-1:0]  cmd_len,
    input  logic [CH_NUM-1:0]            cmd_wait_rel,
    input  logic [CH_NUM-1:0]            release_pulse,
    input  logic [CH_NUM-1:0]            abort,
    input  logic [CH_NUM*DATA_WIDTH-1:0] src_data,
    input  logic [CH_NUM-1:0]            src_valid,
    output logic [CH_NUM-1:0]            src_ready,
    input  logic [CH_NUM-1:0]            pe_fifo_full,
    output logic [CH_NUM-1:0]            pe_start_load,
    output logic [CH_NUM*DATA_WIDTH-1:0] pe_data,
    output logic [CH_NUM-1:0]            pe_data_en,
    output logic [CH_NUM-1:0]            seg_done,
    output logic [CH_NUM-1:0]            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REL,
        S_START,
        S_STREAM,
        S_DONE
    } state_t;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        state_t                 state;
        state_t                 state_nxt;
        logic [LEN_WIDTH-1:0]   len_q;
        logic [LEN_WIDTH-1:0]   beat_cnt;
        logic                   rel_pend;
        logic                   data_en_q;
        logic [DATA_WIDTH-1:0]  data_q;
        logic                   cmd_acc;
        logic                   beat_acc;
        logic                   last_beat;

        // cmd_ready is gated by rst so it stays low for the whole reset window
        assign cmd_ready[n] = (state == S_IDLE) && !rst && !abort[n];
        assign src_ready[n] = (state == S_STREAM) && !pe_fifo_full[n];
        assign cmd_acc      = cmd_valid[n] && cmd_ready[n];
        assign beat_acc     = src_valid[n] && src_ready[n];
        assign last_beat    = (beat_cnt == len_q - LEN_WIDTH'(1));

        assign pe_start_load[n] = (state == S_START);
        assign seg_done[n]      = (state == S_DONE) && !abort[n];
        assign busy[n]          = (state != S_IDLE);
        assign pe_data_en[n]    = data_en_q;
        assign pe_data[n*DATA_WIDTH +: DATA_WIDTH] = data_q;

        always_comb begin
            state_nxt = state;
            if (abort[n]) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:     if (cmd_acc) state_nxt = cmd_wait_rel[n] ? S_WAIT_REL : S_START;
                    S_WAIT_REL: if (release_pulse[n] || rel_pend) state_nxt = S_START;
                    S_START:    state_nxt = (len_q == '0) ? S_DONE : S_STREAM;
                    S_STREAM:   if (beat_acc && last_beat) state_nxt = S_DONE;
                    S_DONE:     state_nxt = S_IDLE;
                    default:    state_nxt = S_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= S_IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                len_q     <= '0;
                beat_cnt  <= '0;
                rel_pend  <= 1'b0;
                data_en_q <= 1'b0;
                data_q    <= '0;
            end else if (abort[n]) begin
                beat_cnt  <= '0;
                rel_pend  <= 1'b0;
                data_en_q <= 1'b0;
            end else begin
                data_en_q <= beat_acc;
                if (beat_acc) begin
                    data_q <= src_data[n*DATA_WIDTH +: DATA_WIDTH];
                end
                if (cmd_acc) begin
                    len_q    <= cmd_len[n*LEN_WIDTH +: LEN_WIDTH];
                    beat_cnt <= '0;
                end else if (beat_acc) begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                end
                // WAIT_REL consumes the pending release; any other state remembers one
                if (state == S_WAIT_REL) begin
                    rel_pend <= 1'b0;
                end else if (release_pulse[n]) begin
                    rel_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_load_sequencer.sv
// tb/tb_pe_load_sequencer.sv - directed self-checking bench for pe_load_sequencer
module tb_pe_load_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cmd_valid, cmd_ready, cmd_wait_rel, release_pulse, abort;
    logic [15:0] cmd_len;
    logic [31:0] src_data, pe_data;
    logic [1:0]  src_valid, src_ready, pe_fifo_full, pe_start_load, pe_data_en, seg_done, busy;

    logic [15:0] src_word [2];
    assign src_data = {src_word[1], src_word[0]};

    pe_load_sequencer #(.DATA_WIDTH(16), .CH_NUM(2), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_wait_rel(cmd_wait_rel), .release_pulse(release_pulse), .abort(abort),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .pe_fifo_full(pe_fifo_full), .pe_start_load(pe_start_load),
        .pe_data(pe_data), .pe_data_en(pe_data_en), .seg_done(seg_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int n_start[2], n_done[2], n_rdy[2], n_acc[2], n_stall[2], n_en[2];
    int start_cyc[2], first_en[2], last_en[2], done_cyc[2], cmd_cyc[2], rel_cyc[2];
    bit acc[2];
    logic [15:0] rx0[$];
    logic [15:0] rx1[$];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Passive monitor: logs what the DUT shows between clock edges
    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (pe_data_en[n]) begin
                if (n_en[n] == 0) first_en[n] = cyc;
                last_en[n] = cyc;
                n_en[n]++;
                if (n == 0) rx0.push_back(pe_data[15:0]);
                else        rx1.push_back(pe_data[31:16]);
            end
            if (pe_start_load[n]) begin n_start[n]++; start_cyc[n] = cyc; end
            if (seg_done[n])      begin n_done[n]++;  done_cyc[n]  = cyc; end
            if (src_ready[n]) n_rdy[n]++;
            if (busy[n] && !pe_start_load[n] && !seg_done[n] && !src_ready[n]) n_stall[n]++;
            if (cmd_valid[n] && cmd_ready[n]) cmd_cyc[n] = cyc;
            if (release_pulse[n]) rel_cyc[n] = cyc;
            acc[n] = src_valid[n] && src_ready[n] && !rst;
            if (acc[n]) n_acc[n]++;
        end
        cyc++;
    end

    // Upstream source: next word presented after each accepted beat
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 2; n++) if (acc[n]) src_word[n] = src_word[n] + 16'd1;
    end

    task automatic ticks(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        for (int n = 0; n < 2; n++) begin
            n_start[n] = 0; n_done[n] = 0; n_rdy[n] = 0; n_acc[n] = 0; n_stall[n] = 0; n_en[n] = 0;
            start_cyc[n] = 0; first_en[n] = 0; last_en[n] = 0; done_cyc[n] = 0;
            cmd_cyc[n] = 0; rel_cyc[n] = 0; src_word[n] = 16'd1;
        end
        rx0.delete();
        rx1.delete();
    endtask

    task automatic issue(input int ch, input int len, input bit wr);
        int b = 0;
        while (!cmd_ready[ch] && b < 20) begin ticks(1); b++; end
        check_eq($sformatf("ch%0d_cmd_ready_before_issue", ch), cmd_ready[ch], 1);
        cmd_len[ch*8 +: 8] = len[7:0];
        cmd_wait_rel[ch] = wr;
        cmd_valid[ch] = 1'b1;
        ticks(1);
        cmd_valid[ch] = 1'b0;
    endtask

    task automatic wait_done(input int ch, input int budget);
        int b = 0;
        while (n_done[ch] == 0 && b < budget) begin ticks(1); b++; end
        ticks(2);
    endtask

    task automatic wait_acc(input int ch, input int k);
        int b = 0;
        while (n_acc[ch] < k && b < 50) begin ticks(1); b++; end
        check_eq($sformatf("ch%0d_beats_reached", ch), n_acc[ch], k);
    endtask

    task automatic check_rx(input int ch, input int base, input int n);
        int sz;
        sz = (ch == 0) ? rx0.size() : rx1.size();
        check_eq($sformatf("ch%0d_rx_count", ch), sz, n);
        for (int i = 0; i < n && i < sz; i++)
            check_eq($sformatf("ch%0d_rx[%0d]", ch, i), (ch == 0) ? rx0[i] : rx1[i], base + i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_base;
        rst = 1'b1;
        cmd_valid = '0; cmd_wait_rel = '0; release_pulse = '0; abort = '0;
        cmd_len = '0; src_valid = '0; pe_fifo_full = '0;
        clr();
        ticks(2);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_pe_data_en", pe_data_en, 0);
        check_eq("rst_pe_data", pe_data, 0);
        check_eq("rst_src_ready", src_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_cmd_ready", cmd_ready, 3);
        ticks(1);
        src_valid = 2'b11;

        // ch0 len 6, no release wait
        clr();
        issue(0, 6, 0);
        wait_done(0, 50);
        check_eq("l6_start_count", n_start[0], 1);
        check_eq("l6_cmd_to_start", start_cyc[0] - cmd_cyc[0], 1);
        check_eq("l6_start_to_first_en", first_en[0] - start_cyc[0], 2);
        check_eq("l6_en_span", last_en[0] - first_en[0], 5);
        check_eq("l6_done_with_last_word", done_cyc[0], last_en[0]);
        check_eq("l6_done_count", n_done[0], 1);
        check_rx(0, 1, 6);

        // ch1 len 9 with a 3-cycle FIFO-full stall after beat 4
        clr();
        issue(1, 9, 0);
        wait_acc(1, 4);
        pe_fifo_full[1] = 1'b1;
        ticks(3);
        pe_fifo_full[1] = 1'b0;
        wait_done(1, 50);
        check_eq("stall_src_ready_low_cycles", n_stall[1], 3);
        check_eq("stall_done_count", n_done[1], 1);
        check_rx(1, 1, 9);

        // release arriving while parked in WAIT_REL
        clr();
        issue(0, 2, 1);
        ticks(4);
        check_eq("wr_no_start_yet", n_start[0], 0);
        check_eq("wr_busy", busy[0], 1);
        check_eq("wr_cmd_ready_low", cmd_ready[0], 0);
        release_pulse[0] = 1'b1;
        ticks(1);
        release_pulse[0] = 1'b0;
        wait_done(0, 50);
        check_eq("wr_rel_to_start", start_cyc[0] - rel_cyc[0], 1);
        check_eq("wr_done_count", n_done[0], 1);
        check_rx(0, 1, 2);

        // release pulsed while idle, before the command
        clr();
        release_pulse[0] = 1'b1;
        ticks(1);
        release_pulse[0] = 1'b0;
        ticks(2);
        issue(0, 1, 1);
        wait_done(0, 50);
        check_eq("pend_cmd_to_start", start_cyc[0] - cmd_cyc[0], 2);
        check_eq("pend_done_count", n_done[0], 1);

        // release in the same cycle as the command accept
        clr();
        cmd_len[7:0] = 8'd1; cmd_wait_rel[0] = 1'b1; cmd_valid[0] = 1'b1; release_pulse[0] = 1'b1;
        ticks(1);
        cmd_valid[0] = 1'b0; release_pulse[0] = 1'b0;
        wait_done(0, 50);
        check_eq("same_cyc_cmd_to_start", start_cyc[0] - cmd_cyc[0], 2);

        // pending release was consumed: next wait_rel segment must park
        clr();
        issue(0, 1, 1);
        ticks(6);
        check_eq("pend_cleared_no_start", n_start[0], 0);
        abort[0] = 1'b1;
        ticks(1);
        abort[0] = 1'b0;
        check_eq("abort_wait_rel_idle", busy[0], 0);

        // zero-length segment
        clr();
        issue(0, 0, 0);
        wait_done(0, 50);
        check_eq("l0_start_count", n_start[0], 1);
        check_eq("l0_done_count", n_done[0], 1);
        check_eq("l0_start_to_done", done_cyc[0] - start_cyc[0], 1);
        check_eq("l0_no_data_en", n_en[0], 0);
        check_eq("l0_no_src_ready", n_rdy[0], 0);

        // abort at beat 3 of 12, then a clean len 2 segment
        clr();
        issue(0, 12, 0);
        wait_acc(0, 3);
        abort[0] = 1'b1;
        ticks(1);
        abort[0] = 1'b0;
        check_eq("abort_busy", busy[0], 0);
        check_eq("abort_data_en", pe_data_en[0], 0);
        ticks(3);
        check_eq("abort_no_done", n_done[0], 0);
        check_rx(0, 1, 3);
        clr();
        issue(0, 2, 0);
        wait_done(0, 50);
        check_eq("after_abort_done", n_done[0], 1);
        check_rx(0, 1, 2);

        // both channels concurrently
        clr();
        cmd_len = {8'd102, 8'd12}; cmd_wait_rel = 2'b00; cmd_valid = 2'b11;
        ticks(1);
        cmd_valid = 2'b00;
        wait_done(1, 300);
        check_eq("conc_ch0_done", n_done[0], 1);
        check_eq("conc_ch1_done", n_done[1], 1);
        check_rx(0, 1, 12);
        check_rx(1, 1, 102);

        // repeat, with rst asserted mid-run
        clr();
        cmd_len = {8'd102, 8'd12}; cmd_valid = 2'b11;
        ticks(1);
        cmd_valid = 2'b00;
        ticks(8);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_data_en", pe_data_en, 0);
        check_eq("mid_rst_src_ready", src_ready, 0);
        check_eq("mid_rst_cmd_ready", cmd_ready, 0);
        check_eq("mid_rst_start", pe_start_load, 0);
        check_eq("mid_rst_seg_done", seg_done, 0);
        check_eq("mid_rst_pe_data", pe_data, 0);
        en_base = n_en[0] + n_en[1];
        ticks(2);
        rst = 1'b0;
        #1;
        check_eq("after_rst_cmd_ready", cmd_ready, 3);
        ticks(10);
        check_eq("after_rst_no_data_en", n_en[0] + n_en[1], en_base);
        check_eq("after_rst_no_done", n_done[0] + n_done[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
